// File: rtl/ip_reg_stack.sv
// Purpose: program-counter style register with increment, load and a LIFO return stack for call/ret.
// Latency: one cycle; every command updates Dout/depth/flags on the rising edge where it is sampled.
// Backpressure: none; call while full and ret while empty are absorbed and flagged in sticky errors.
module ip_reg_stack #(
    parameter int                 WIDTH     = 32,
    parameter int                 STEP      = 1,
    parameter int                 DEPTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ld,
    input  logic                       inc,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       clr_err,
    input  logic [WIDTH-1:0]           Din,
    output logic [WIDTH-1:0]           Dout,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       full,
    output logic                       empty,
    output logic                       wrap,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    localparam logic [WIDTH:0]  STEP_X  = (WIDTH+1)'(STEP);
    localparam logic [DW-1:0]   ONE     = DW'(1);
    localparam logic [DW-1:0]   DEPTH_V = DW'(DEPTH);

    logic [WIDTH-1:0] dout_q,  dout_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             wrap_q,  wrap_d;
    logic             ovf_q,   ovf_d;
    logic             unf_q,   unf_d;

    // Stack storage is never reset; depth_q alone decides which entries are live.
    logic [WIDTH-1:0] stack_q [DEPTH];

    logic             push_en;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    pop_idx;
    logic [DW-1:0]    depth_m1;
    logic [WIDTH:0]   sum;
    logic             full_w;
    logic             empty_w;

    // Status comes purely from the registered depth, so full/empty have no input-to-output path.
    always_comb begin
        full_w   = (depth_q == DEPTH_V);
        empty_w  = (depth_q == '0);
        depth_m1 = depth_q - ONE;
        push_idx = depth_q[AW-1:0];
        pop_idx  = depth_m1[AW-1:0];
        sum      = {1'b0, dout_q} + STEP_X;
    end

    // Command decode: call > ret > ld > inc > hold; error events override a same-cycle clr_err.
    always_comb begin
        dout_d  = dout_q;
        depth_d = depth_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;

        if (clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end

        if (call) begin
            dout_d = Din;
            if (!full_w) begin
                push_en = 1'b1;
                depth_d = depth_q + ONE;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (ret) begin
            if (!empty_w) begin
                dout_d  = stack_q[pop_idx];
                depth_d = depth_m1;
            end else begin
                unf_d = 1'b1;
            end
        end else if (ld) begin
            dout_d = Din;
        end else if (inc) begin
            dout_d = sum[WIDTH-1:0];
            wrap_d = sum[WIDTH];
        end
    end

    // Architectural state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q  <= RESET_VAL;
            depth_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            depth_q <= depth_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address write: the pushed value is the address following the current one.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= sum[WIDTH-1:0];
        end
    end

    assign Dout    = dout_q;
    assign depth   = depth_q;
    assign full    = full_w;
    assign empty   = empty_w;
    assign wrap    = wrap_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule
